spi_cmd_frontend: RTL and testbench



---
 rtl/spi_cmd_frontend.sv | 185 ++++++++++++++++++
 tb/tb_spi_cmd_frontend.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_cmd_frontend.sv
// SPI mode-0 slave front end: deserialises command words, presents them with a stretched
// commit strobe, and echoes the last committed word on MISO.
module spi_cmd_frontend #(
  parameter int unsigned WORD_WIDTH    = 32,
  parameter int unsigned STROBE_CYCLES = 4,
  parameter int unsigned SYNC_STAGES   = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  spi_sclk,
  input  logic                  spi_cs_n,
  input  logic                  spi_mosi,
  output logic                  spi_miso,
  output logic                  spi_miso_oeb,
  output logic [WORD_WIDTH-1:0] spi_data,
  output logic                  spi_data_clock,
  output logic                  frame_error,
  output logic                  overrun
);

  localparam int unsigned CntW  = 6;
  localparam int unsigned StrW  = $clog2(STROBE_CYCLES + 1);
  localparam int unsigned WarmW = $clog2(SYNC_STAGES + 1);
  localparam logic [CntW-1:0]  FullCnt = CntW'(WORD_WIDTH);
  localparam logic [StrW-1:0]  StrLoad = StrW'(STROBE_CYCLES - 1);
  localparam logic [WarmW-1:0] WarmMax = WarmW'(SYNC_STAGES);

  typedef enum logic [1:0] {OutIdle, OutSetup, OutHigh, OutLow} out_state_e;

  logic [SYNC_STAGES-1:0] r_sclk_sync, r_cs_n_sync, r_mosi_sync;
  logic                   r_sclk_d, r_cs_n_d;
  logic                   w_sclk, w_cs_n, w_mosi;
  logic                   w_sclk_rise, w_sclk_fall, w_cs_fall, w_cs_rise;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sclk_sync <= '0;
      r_cs_n_sync <= '1;
      r_mosi_sync <= '0;
      r_sclk_d    <= 1'b0;
      r_cs_n_d    <= 1'b1;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      r_cs_n_sync <= {r_cs_n_sync[SYNC_STAGES-2:0], spi_cs_n};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      r_sclk_d    <= w_sclk;
      r_cs_n_d    <= w_cs_n;
    end
  end

  assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
  assign w_cs_n      = r_cs_n_sync[SYNC_STAGES-1];
  assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
  assign w_sclk_rise = w_sclk & ~r_sclk_d;
  assign w_sclk_fall = ~w_sclk & r_sclk_d;
  assign w_cs_fall   = ~w_cs_n & r_cs_n_d;
  assign w_cs_rise   = w_cs_n & ~r_cs_n_d;

  // The synchroniser preset fakes a cs_n fall if the pin is low at release, so a frame may
  // only start once a genuine high level has propagated through the whole chain.
  logic [WarmW-1:0] r_warm_cnt;
  logic             r_idle_seen;
  logic             w_frame_start;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_warm_cnt  <= '0;
      r_idle_seen <= 1'b0;
    end else begin
      if (r_warm_cnt != WarmMax) r_warm_cnt <= r_warm_cnt + 1'b1;
      if (r_warm_cnt == WarmMax && w_cs_n) r_idle_seen <= 1'b1;
    end
  end

  assign w_frame_start = w_cs_fall & r_idle_seen;

  logic                  r_in_frame;
  logic [CntW-1:0]       r_bit_count;
  logic [WORD_WIDTH-1:0] r_shift;
  logic                  w_frame_end, w_word_valid, w_frame_bad;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_in_frame  <= 1'b0;
      r_bit_count <= '0;
      r_shift     <= '0;
    end else if (w_frame_start) begin
      r_in_frame  <= 1'b1;
      r_bit_count <= '0;
      r_shift     <= '0;
    end else if (w_cs_rise) begin
      r_in_frame  <= 1'b0;
    end else if (r_in_frame && w_sclk_rise) begin
      if (r_bit_count < FullCnt) r_shift <= {r_shift[WORD_WIDTH-2:0], w_mosi};
      if (r_bit_count != '1) r_bit_count <= r_bit_count + 1'b1;
    end
  end

  assign w_frame_end  = w_cs_rise & r_in_frame;
  assign w_word_valid = w_frame_end & (r_bit_count == FullCnt);
  assign w_frame_bad  = w_frame_end & (r_bit_count != FullCnt);

  out_state_e            r_state;
  logic [StrW-1:0]       r_str_cnt;
  logic [WORD_WIDTH-1:0] r_data, r_pend_data;
  logic                  r_data_clock, r_pend_valid, r_frame_error, r_overrun;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= OutIdle;
      r_str_cnt     <= '0;
      r_data        <= '0;
      r_data_clock  <= 1'b0;
      r_pend_valid  <= 1'b0;
      r_pend_data   <= '0;
      r_frame_error <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      r_frame_error <= w_frame_bad;
      r_overrun     <= 1'b0;
      unique case (r_state)
        OutIdle: begin
          if (r_pend_valid) begin
            r_data  <= r_pend_data;
            r_state <= OutSetup;
            // Pending goes out first; a word ending now takes its place in the slot.
            if (w_word_valid) r_pend_data <= r_shift;
            else              r_pend_valid <= 1'b0;
          end else if (w_word_valid) begin
            r_data  <= r_shift;
            r_state <= OutSetup;
          end
        end
        OutSetup: begin
          r_data_clock <= 1'b1;
          r_str_cnt    <= StrLoad;
          r_state      <= OutHigh;
        end
        OutHigh: begin
          if (r_str_cnt == '0) begin
            r_data_clock <= 1'b0;
            r_str_cnt    <= StrLoad;
            r_state      <= OutLow;
          end else begin
            r_str_cnt <= r_str_cnt - 1'b1;
          end
        end
        OutLow: begin
          if (r_str_cnt == '0) r_state <= OutIdle;
          else                 r_str_cnt <= r_str_cnt - 1'b1;
        end
        default: r_state <= OutIdle;
      endcase
      if (r_state != OutIdle && w_word_valid) begin
        if (r_pend_valid) begin
          r_overrun <= 1'b1;
        end else begin
          r_pend_valid <= 1'b1;
          r_pend_data  <= r_shift;
        end
      end
    end
  end

  // MISO is the shifter MSB; zeros fill from the bottom so it reads 0 once the word is out.
  logic [WORD_WIDTH-1:0] r_miso_shift;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_miso_shift <= '0;
    end else if (w_frame_start) begin
      r_miso_shift <= r_data;
    end else if (r_in_frame && w_sclk_fall) begin
      r_miso_shift <= {r_miso_shift[WORD_WIDTH-2:0], 1'b0};
    end
  end

  assign spi_miso       = r_miso_shift[WORD_WIDTH-1];
  assign spi_miso_oeb   = w_cs_n;
  assign spi_data       = r_data;
  assign spi_data_clock = r_data_clock;
  assign frame_error    = r_frame_error;
  assign overrun        = r_overrun;

endmodule

// File: tb/tb_spi_cmd_frontend.sv
// Directed bench: a default-strobe instance for timing/MISO/reset checks and a long-strobe
// instance sharing the same pins so frames can overlap the output handshake.
`timescale 1ns/1ps
module tb_spi_cmd_frontend;

  localparam int unsigned LongStrobe = 400;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic sclk = 1'b0;
  logic cs_n = 1'b1;
  logic mosi = 1'b0;

  logic        a_miso, a_oeb, a_dclk, a_fe, a_ov;
  logic [31:0] a_data;
  logic        b_miso, b_oeb, b_dclk, b_fe, b_ov;
  logic [31:0] b_data;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  spi_cmd_frontend #(.WORD_WIDTH(32), .STROBE_CYCLES(4), .SYNC_STAGES(2)) u_dut (
    .clock(clock), .reset(reset), .spi_sclk(sclk), .spi_cs_n(cs_n), .spi_mosi(mosi),
    .spi_miso(a_miso), .spi_miso_oeb(a_oeb), .spi_data(a_data), .spi_data_clock(a_dclk),
    .frame_error(a_fe), .overrun(a_ov)
  );

  spi_cmd_frontend #(.WORD_WIDTH(32), .STROBE_CYCLES(LongStrobe), .SYNC_STAGES(2)) u_dut_long (
    .clock(clock), .reset(reset), .spi_sclk(sclk), .spi_cs_n(cs_n), .spi_mosi(mosi),
    .spi_miso(b_miso), .spi_miso_oeb(b_oeb), .spi_data(b_data), .spi_data_clock(b_dclk),
    .frame_error(b_fe), .overrun(b_ov)
  );

  // Event monitors sampled on the falling clock edge.
  int   a_fe_cnt = 0, a_ov_cnt = 0, a_rise_cnt = 0;
  logic a_prev_dclk = 1'b0;

  always @(negedge clock) begin
    a_prev_dclk <= a_dclk;
    a_fe_cnt    <= a_fe_cnt + int'(a_fe);
    a_ov_cnt    <= a_ov_cnt + int'(a_ov);
    if (a_dclk && !a_prev_dclk) a_rise_cnt <= a_rise_cnt + 1;
  end

  int          b_cyc = 0, b_rise_cyc = 0, b_fall_cyc = -100000;
  int          b_fe_cnt = 0, b_ov_cnt = 0, b_rise_cnt = 0, b_unstable = 0;
  logic        b_prev_dclk = 1'b0;
  logic [31:0] b_prev_data = '0;
  logic [31:0] b_log_data [8];
  int          b_log_high [8];
  int          b_log_gap  [8];
  bit          b_log_setup[8];

  always @(negedge clock) begin
    b_cyc       <= b_cyc + 1;
    b_prev_dclk <= b_dclk;
    b_prev_data <= b_data;
    b_fe_cnt    <= b_fe_cnt + int'(b_fe);
    b_ov_cnt    <= b_ov_cnt + int'(b_ov);
    if (b_dclk && !b_prev_dclk && b_rise_cnt < 8) begin
      b_log_data[b_rise_cnt]  <= b_data;
      b_log_setup[b_rise_cnt] <= (b_prev_data === b_data);
      b_log_gap[b_rise_cnt]   <= b_cyc - b_fall_cyc;
      b_rise_cyc              <= b_cyc;
      b_rise_cnt              <= b_rise_cnt + 1;
    end
    if (!b_dclk && b_prev_dclk && b_rise_cnt > 0 && b_rise_cnt <= 8) begin
      b_log_high[b_rise_cnt-1] <= b_cyc - b_rise_cyc;
      b_fall_cyc               <= b_cyc;
    end
    if (b_dclk && b_prev_dclk && b_data !== b_prev_data) b_unstable <= b_unstable + 1;
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Lowers cs_n and clocks nbits (MSB first) of val; leaves cs_n low on a falling clock edge.
  task automatic shift_bits(input logic [63:0] val, input int nbits,
                            output logic [31:0] rx, output int oeb_bad);
    rx = '0;
    oeb_bad = 0;
    @(negedge clock);
    cs_n = 1'b0;
    sclk = 1'b0;
    wait_cycles(4);
    for (int i = 0; i < nbits; i++) begin
      mosi = val[nbits-1-i];
      wait_cycles(4);
      if (i < 32) rx = {rx[30:0], a_miso};
      if (a_oeb !== 1'b0) oeb_bad++;
      sclk = 1'b1;
      wait_cycles(4);
      sclk = 1'b0;
    end
    wait_cycles(4);
  endtask

  task automatic test_reset();
    wait_cycles(3);
    checks++; if (a_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", a_data); end
    checks++; if (a_dclk !== 1'b0) begin errors++; $display("FAIL reset_dclk: got %b expected 0", a_dclk); end
    checks++; if (a_miso !== 1'b0) begin errors++; $display("FAIL reset_miso: got %b expected 0", a_miso); end
    checks++; if (a_oeb !== 1'b1) begin errors++; $display("FAIL reset_oeb: got %b expected 1", a_oeb); end
    checks++; if (a_fe !== 1'b0 || a_ov !== 1'b0) begin
      errors++; $display("FAIL reset_pulses: got fe=%b ov=%b expected 0 0", a_fe, a_ov);
    end
    checks++; if (b_data !== 32'h0 || b_dclk !== 1'b0) begin
      errors++; $display("FAIL reset_long: got data=%h dclk=%b expected 0 0", b_data, b_dclk);
    end
    reset = 1'b0;
    wait_cycles(8);
  endtask

  task automatic test_single_frame();
    logic [31:0] rx, exp_data;
    logic        exp_clk;
    int          ob, fe0;
    fe0 = a_fe_cnt;
    shift_bits(64'hA5A5_0F0F, 32, rx, ob);
    cs_n = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clock);
      exp_data = (k >= 3) ? 32'hA5A5_0F0F : 32'h0;
      exp_clk  = (k >= 4 && k <= 7);
      checks++; if (a_data !== exp_data) begin
        errors++; $display("FAIL single_data[%0d]: got %h expected %h", k, a_data, exp_data);
      end
      checks++; if (a_dclk !== exp_clk) begin
        errors++; $display("FAIL single_dclk[%0d]: got %b expected %b", k, a_dclk, exp_clk);
      end
    end
    wait_cycles(4);
    checks++; if (a_fe_cnt !== fe0) begin
      errors++; $display("FAIL single_no_fe: got %0d expected %0d", a_fe_cnt, fe0);
    end
  endtask

  task automatic test_frame_error();
    logic [63:0] vals[2];
    int          lens[2];
    logic [31:0] rx;
    int          ob, fe0, r0;
    vals[0] = 64'h0_000A_BCDE; lens[0] = 20;
    vals[1] = 64'h1_FFFF_0000; lens[1] = 33;
    for (int c = 0; c < 2; c++) begin
      wait_cycles(10);
      fe0 = a_fe_cnt;
      r0  = a_rise_cnt;
      shift_bits(vals[c], lens[c], rx, ob);
      cs_n = 1'b1;
      wait_cycles(12);
      checks++; if (a_fe_cnt - fe0 !== 1) begin
        errors++; $display("FAIL ferr_pulse_%0d: got %0d cycles expected 1", lens[c], a_fe_cnt - fe0);
      end
      checks++; if (a_rise_cnt !== r0) begin
        errors++; $display("FAIL ferr_strobe_%0d: got %0d strobes expected 0", lens[c], a_rise_cnt - r0);
      end
      checks++; if (a_data !== 32'hA5A5_0F0F || a_dclk !== 1'b0) begin
        errors++;
        $display("FAIL ferr_hold_%0d: got data=%h dclk=%b expected a5a50f0f 0", lens[c], a_data, a_dclk);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rx;
    int          ob, n0, ov0, fe0, waited;
    wait_cycles(900);
    n0  = b_rise_cnt;
    ov0 = b_ov_cnt;
    fe0 = b_fe_cnt;
    shift_bits(64'h1111_1111, 32, rx, ob);
    cs_n = 1'b1;
    wait_cycles(8);
    shift_bits(64'h2222_2222, 32, rx, ob);
    cs_n = 1'b1;
    wait_cycles(4);
    checks++; if (b_dclk !== 1'b1) begin
      errors++; $display("FAIL b2b_second_in_high: got dclk=%b expected 1", b_dclk);
    end
    wait_cycles(4);
    shift_bits(64'h3333_3333, 32, rx, ob);
    cs_n = 1'b1;
    wait_cycles(4);
    checks++; if (b_dclk !== 1'b0 || b_rise_cnt !== n0 + 1) begin
      errors++; $display("FAIL b2b_third_early: got dclk=%b strobes=%0d expected 0 %0d",
                         b_dclk, b_rise_cnt - n0, 1);
    end
    checks++; if (b_ov_cnt - ov0 !== 1) begin
      errors++; $display("FAIL b2b_overrun: got %0d expected 1", b_ov_cnt - ov0);
    end
    waited = 0;
    while (b_rise_cnt < n0 + 2 && waited < 2000) begin
      wait_cycles(1);
      waited++;
    end
    checks++; if (b_rise_cnt < n0 + 2) begin
      errors++; $display("FAIL b2b_timeout: got %0d strobes expected 2", b_rise_cnt - n0);
    end
    wait_cycles(900);
    checks++; if (b_rise_cnt !== n0 + 2) begin
      errors++; $display("FAIL b2b_count: got %0d strobes expected 2", b_rise_cnt - n0);
    end
    if (n0 + 1 < 8) begin
      checks++; if (b_log_data[n0] !== 32'h1111_1111 || b_log_data[n0+1] !== 32'h2222_2222) begin
        errors++; $display("FAIL b2b_order: got %h %h expected 11111111 22222222",
                           b_log_data[n0], b_log_data[n0+1]);
      end
      checks++; if (!b_log_setup[n0] || !b_log_setup[n0+1]) begin
        errors++; $display("FAIL b2b_setup: got %b %b expected 1 1", b_log_setup[n0], b_log_setup[n0+1]);
      end
      checks++; if (b_log_high[n0] !== LongStrobe || b_log_high[n0+1] !== LongStrobe) begin
        errors++; $display("FAIL b2b_high: got %0d %0d expected %0d", b_log_high[n0],
                           b_log_high[n0+1], LongStrobe);
      end
      checks++; if (b_log_gap[n0+1] < LongStrobe) begin
        errors++; $display("FAIL b2b_gap: got %0d expected >= %0d", b_log_gap[n0+1], LongStrobe);
      end
    end
    checks++; if (b_unstable !== 0 || b_fe_cnt !== fe0) begin
      errors++; $display("FAIL b2b_clean: got unstable=%0d fe=%0d expected 0 0", b_unstable,
                         b_fe_cnt - fe0);
    end
  endtask

  task automatic test_miso();
    logic [31:0] rx;
    int          ob;
    wait_cycles(10);
    shift_bits(64'hDEAD_BEEF, 32, rx, ob);
    cs_n = 1'b1;
    wait_cycles(20);
    checks++; if (a_data !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL miso_commit: got %h expected deadbeef", a_data);
    end
    checks++; if (a_oeb !== 1'b1) begin
      errors++; $display("FAIL miso_oeb_idle: got %b expected 1", a_oeb);
    end
    shift_bits(64'h0, 32, rx, ob);
    cs_n = 1'b1;
    checks++; if (rx !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL miso_readback: got %h expected deadbeef", rx);
    end
    checks++; if (ob !== 0) begin
      errors++; $display("FAIL miso_oeb_active: got %0d high samples expected 0", ob);
    end
    wait_cycles(20);
    checks++; if (a_oeb !== 1'b1 || a_data !== 32'h0) begin
      errors++; $display("FAIL miso_after: got oeb=%b data=%h expected 1 0", a_oeb, a_data);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] rx;
    int          ob, fe0, r0;
    wait_cycles(10);
    fe0 = a_fe_cnt;
    r0  = a_rise_cnt;
    shift_bits(64'hFFFF, 16, rx, ob);
    reset = 1'b1;
    wait_cycles(3);
    reset = 1'b0;
    wait_cycles(2);
    shift_bits(64'h5555, 16, rx, ob);
    cs_n = 1'b1;
    wait_cycles(20);
    checks++; if (a_rise_cnt !== r0 || a_dclk !== 1'b0) begin
      errors++; $display("FAIL rstmid_strobe: got %0d strobes expected 0", a_rise_cnt - r0);
    end
    checks++; if (a_fe_cnt !== fe0) begin
      errors++; $display("FAIL rstmid_ferr: got %0d expected 0", a_fe_cnt - fe0);
    end
    checks++; if (a_data !== 32'h0) begin
      errors++; $display("FAIL rstmid_data: got %h expected 0", a_data);
    end
    shift_bits(64'h1234_5678, 32, rx, ob);
    cs_n = 1'b1;
    wait_cycles(12);
    checks++; if (a_rise_cnt !== r0 + 1 || a_data !== 32'h1234_5678) begin
      errors++; $display("FAIL rstmid_next: got strobes=%0d data=%h expected 1 12345678",
                         a_rise_cnt - r0, a_data);
    end
    checks++; if (a_fe_cnt !== fe0) begin
      errors++; $display("FAIL rstmid_next_ferr: got %0d expected 0", a_fe_cnt - fe0);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_frame_error();
    test_back_to_back();
    test_miso();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
